// File: rtl/instr_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
// Stored words drop the always-11 low bits of a 32-bit RV instruction.
package iq_pkg;

   localparam logic [31:0] NOP       = 32'h00000013;
   localparam int          IQ_DEPTH  = 8;
   localparam int          IQ_IWIDTH = 30;

   function automatic logic [31:0] expand_instr(input logic [IQ_IWIDTH-1:0] x);
      return {x, 2'b11};
   endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-to-decode queue bus: the IF push side and the decode valid/pop side.
interface instr_queue_if
   import iq_pkg::*;
#(
   parameter int DEPTH  = IQ_DEPTH,
   parameter int IWIDTH = IQ_IWIDTH
);

   logic                     push;
   logic [IWIDTH-1:0]        instr;
   logic                     queueFull;
   logic                     outValid;
   logic [31:0]              outInstr;
   logic                     pop;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;

   modport master (
      output push, instr, pop,
      input  queueFull, outValid, outInstr, count, overflow
   );

   modport slave (
      input  push, instr, pop,
      output queueFull, outValid, outInstr, count, overflow
   );

endinterface

// File: rtl/instr_queue_storage.sv
// Register file for queued instruction words: one synchronous write port,
// one asynchronous read port. Contents are deliberately never reset.
module iq_storage #(
   parameter int DEPTH  = 8,
   parameter int IWIDTH = 30
) (
   input  logic                     clock,
   input  logic                     wrEn,
   input  logic [$clog2(DEPTH)-1:0] wrAddr,
   input  logic [IWIDTH-1:0]        wrData,
   input  logic [$clog2(DEPTH)-1:0] rdAddr,
   output logic [IWIDTH-1:0]        rdData
);

   logic [IWIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/instr_queue.sv
// Instruction fetch queue between IF and decode. Optional IQ_BYPASS_EN lets
// a push into an empty queue reach decode in the same cycle.
module instr_queue
   import iq_pkg::*;
#(
   parameter int DEPTH  = IQ_DEPTH,
   parameter int IWIDTH = IQ_IWIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   instr_queue_if.slave       bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]     wrPtr;
   logic [AW-1:0]     rdPtr;
   logic [CW-1:0]     count;
   logic              overflowReg;
   logic [IWIDTH-1:0] headWord;

   logic isFull;
   logic isEmpty;
   logic bypassLive;
   logic bypassTake;
   logic doPush;
   logic doPop;
   logic wrEn;
   logic rdAdv;

   assign isFull  = (count == CW'(DEPTH));
   assign isEmpty = (count == '0);

`ifdef IQ_BYPASS_EN
   assign bypassLive = isEmpty && bus.push && !flush;
`else
   assign bypassLive = 1'b0;
`endif

   // A bypassed word that decode takes immediately never touches storage.
   assign bypassTake = bypassLive && bus.pop;
   assign doPush     = bus.push && !isFull;
   assign doPop      = bus.pop && bus.outValid;
   assign wrEn       = doPush && !bypassTake;
   assign rdAdv      = doPop && !bypassTake;

   assign bus.queueFull = isFull;
   assign bus.count     = count;
   assign bus.overflow  = overflowReg;
   assign bus.outValid  = !isEmpty || bypassLive;
   assign bus.outInstr  = bypassLive ? expand_instr(bus.instr) :
                          (!isEmpty ? expand_instr(headWord) : NOP);

   iq_storage #(
      .DEPTH  (DEPTH),
      .IWIDTH (IWIDTH)
   ) storage (
      .clock  (clock),
      .wrEn   (wrEn && !flush && !reset),
      .wrAddr (wrPtr),
      .wrData (bus.instr),
      .rdAddr (rdPtr),
      .rdData (headWord)
   );

   // Flush keeps the sticky overflow flag so the back end can still see it.
   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr       <= '0;
         rdPtr       <= '0;
         count       <= '0;
         overflowReg <= 1'b0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (wrEn) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (rdAdv) begin
            rdPtr <= rdPtr + 1'b1;
         end
         if (bus.push && isFull) begin
            overflowReg <= 1'b1;
         end
         case ({wrEn, rdAdv})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// Randomised and directed bench for instr_queue, checked against a
// queue-based reference model through an expectation scoreboard.
module tb_instr_queue;
   import iq_pkg::*;

   localparam int DEPTH = 8;

   typedef struct {
      logic        valid;
      logic [31:0] instrWord;
      int          count;
      logic        full;
      logic        ovf;
   } exp_t;

   logic clock;
   logic reset;
   logic flush;

   instr_queue_if #(.DEPTH(DEPTH), .IWIDTH(30)) bus ();

   instr_queue #(.DEPTH(DEPTH), .IWIDTH(30)) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   exp_t        sbQ[$];
   logic [29:0] modelQ[$];
   logic        modelOvf;
   int          checks;
   int          errors;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
      end
   endtask

   // Records what decode should see this cycle, then advances the model past the edge.
   task automatic applyStimulus(input logic rst, input logic fl, input logic ps,
                                input logic [29:0] word, input logic pp, input logic record);
      exp_t e;
      int   sz;
      logic byp;
      reset      = rst;
      flush      = fl;
      bus.push   = ps;
      bus.instr  = word;
      bus.pop    = pp;
      sz         = modelQ.size();
      byp        = 1'b0;
`ifdef IQ_BYPASS_EN
      byp        = (sz == 0) && ps && !fl;
`endif
      e.valid     = (sz != 0) || byp;
      e.instrWord = byp ? {word, 2'b11} : ((sz != 0) ? {modelQ[0], 2'b11} : 32'h00000013);
      e.count     = sz;
      e.full      = (sz == DEPTH);
      e.ovf       = modelOvf;
      if (record) sbQ.push_back(e);
      if (rst) begin
         modelQ.delete();
         modelOvf = 1'b0;
      end else if (fl) begin
         modelQ.delete();
      end else begin
         if (ps && sz == DEPTH) modelOvf = 1'b1;
         if (!(byp && pp)) begin
            if (pp && sz > 0) void'(modelQ.pop_front());
            if (ps && sz < DEPTH) modelQ.push_back(word);
         end
      end
      @(posedge clock);
      #1;
   endtask

   // Monitor: compares every recorded cycle against the live DUT outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("outValid", {31'b0, bus.outValid}, {31'b0, e.valid});
            checkOutput("outInstr", bus.outInstr, e.instrWord);
            checkOutput("count", 32'(bus.count), 32'(e.count));
            checkOutput("queueFull", {31'b0, bus.queueFull}, {31'b0, e.full});
            checkOutput("overflow", {31'b0, bus.overflow}, {31'b0, e.ovf});
         end
      end
   end

   initial begin
      logic [29:0] w;
      int          waitCycles;
      checks   = 0;
      errors   = 0;
      modelOvf = 1'b0;

      applyStimulus(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b1);

      $display("[TB] single addi push then pop");
      applyStimulus(1'b0, 1'b0, 1'b1, 30'h00140024, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 1'b1);

      $display("[TB] fill, overflow, drain");
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b1, 30'(32'h100 + i), 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 1'b1);

      $display("[TB] push and pop while full");
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, 30'(32'h200 + i), 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 30'h2FF, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 1'b1);

      $display("[TB] pointer wrap");
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 30'(32'h300 + 16 * b + i), 1'b0, 1'b1);
         for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 1'b1);
      end

      $display("[TB] flush with push and pop");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 30'(32'h400 + i), 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 30'h4FF, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 30'h450, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 1'b1);

      $display("[TB] reset while holding entries");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 30'(32'h500 + i), 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 30'h5FF, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 30'h00140024, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 1'b1);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         w = 30'($urandom());
         applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 9) < 6), w, ($urandom_range(0, 9) < 5), 1'b1);
      end

      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 1'b1);
      waitCycles = 0;
      while (sbQ.size() > 0 && waitCycles < 10) begin
         @(negedge clock);
         #1;
         waitCycles++;
      end
      if (sbQ.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", sbQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
